// File: rtl/alu_64bit.sv
// ---------------------------------------------------------------------------
// alu_64bit
// Single-cycle-latency integer ALU (RISC-V style opcode {funct7[5], funct3}).
// All outputs are registered. Inputs are sampled on a clock edge when
// in_valid=1, and the result appears after that same edge.
//
// Configuration macro: ALU_SHIFT_EN
//   defined   : SLL/SRL/SRA (0001/0101/1101) are implemented
//   undefined : no shifter is built; those opcodes behave as undefined
//               opcodes (result 0, flags 0)
//
// Ports:
//   clk        in   1      clock, rising edge
//   reset      in   1      asynchronous reset, active low
//   in_valid   in   1      operands/opcode valid this cycle
//   A          in   WIDTH  first operand
//   B          in   WIDTH  second operand
//   Opcode     in   4      operation select
//   ALUoutput  out  WIDTH  registered result
//   Carry      out  1      registered carry (ADD carry-out, SUB no-borrow)
//   Overflow   out  1      registered signed-overflow flag
//   out_valid  out  1      registered copy of in_valid
// ---------------------------------------------------------------------------
module alu_64bit #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       Opcode,
    output logic [WIDTH-1:0] ALUoutput,
    output logic             Carry,
    output logic             Overflow,
    output logic             out_valid
);

    localparam int unsigned SHAMT_W = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b1000;
    localparam logic [3:0] OP_SLT  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_AND  = 4'b0111;
`ifdef ALU_SHIFT_EN
    localparam logic [3:0] OP_SLL  = 4'b0001;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SRA  = 4'b1101;
`endif

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_result;
    logic             w_carry;
    logic             w_overflow;

    logic [WIDTH-1:0] r_result;
    logic             r_carry;
    logic             r_overflow;
    logic             r_valid;

    // One extra bit on the adder/subtractor exposes carry-out / borrow.
    assign w_sum  = {1'b0, A} + {1'b0, B};
    assign w_diff = {1'b0, A} - {1'b0, B};

`ifdef ALU_SHIFT_EN
    logic [SHAMT_W-1:0] w_shamt;
    assign w_shamt = B[SHAMT_W-1:0];
`endif

    // Result and flag selection.
    always_comb begin
        w_result   = '0;
        w_carry    = 1'b0;
        w_overflow = 1'b0;
        case (Opcode)
            OP_ADD: begin
                w_result   = w_sum[WIDTH-1:0];
                w_carry    = w_sum[WIDTH];
                w_overflow = (A[WIDTH-1] == B[WIDTH-1]) &&
                             (w_sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                w_result   = w_diff[WIDTH-1:0];
                // Borrow out of the top bit means A < B unsigned.
                w_carry    = ~w_diff[WIDTH];
                w_overflow = (A[WIDTH-1] != B[WIDTH-1]) &&
                             (w_diff[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SLT:  w_result = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_SLTU: w_result = {{(WIDTH-1){1'b0}}, (A < B)};
            OP_XOR:  w_result = A ^ B;
            OP_OR:   w_result = A | B;
            OP_AND:  w_result = A & B;
`ifdef ALU_SHIFT_EN
            OP_SLL:  w_result = A << w_shamt;
            OP_SRL:  w_result = A >> w_shamt;
            OP_SRA:  w_result = WIDTH'($signed(A) >>> w_shamt);
`endif
            default: begin
                w_result   = '0;
                w_carry    = 1'b0;
                w_overflow = 1'b0;
            end
        endcase
    end

    // Result registers hold while in_valid is low; out_valid tracks in_valid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_result   <= '0;
            r_carry    <= 1'b0;
            r_overflow <= 1'b0;
            r_valid    <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_result   <= w_result;
                r_carry    <= w_carry;
                r_overflow <= w_overflow;
            end
        end
    end

    assign ALUoutput = r_result;
    assign Carry     = r_carry;
    assign Overflow  = r_overflow;
    assign out_valid = r_valid;

endmodule

// File: tb/tb_alu_64bit.sv
// ---------------------------------------------------------------------------
// tb_alu_64bit
// Directed-vector self-checking bench for alu_64bit. Inputs are driven on the
// falling edge and outputs are sampled on the following falling edge, so each
// vector's result is observed after exactly one rising edge.
// Shift expectations follow ALU_SHIFT_EN, the same macro the RTL uses.
// ---------------------------------------------------------------------------
module tb_alu_64bit;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [63:0] A;
    logic [63:0] B;
    logic [3:0]  Opcode;
    logic [63:0] ALUoutput;
    logic        Carry;
    logic        Overflow;
    logic        out_valid;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    alu_64bit #(.WIDTH(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .Opcode    (Opcode),
        .ALUoutput (ALUoutput),
        .Carry     (Carry),
        .Overflow  (Overflow),
        .out_valid (out_valid)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one vector at the falling edge, wait one full cycle.
    task automatic drive(input logic [3:0] op, input logic [63:0] a,
                         input logic [63:0] b, input logic v);
        @(negedge clk);
        Opcode   = op;
        A        = a;
        B        = b;
        in_valid = v;
        @(negedge clk);
    endtask

    task automatic check_all(input string tag, input logic [63:0] res,
                             input logic c, input logic o, input logic v);
        check({tag, ".res"}, ALUoutput, res);
        check({tag, ".c"},   64'(Carry), 64'(c));
        check({tag, ".ov"},  64'(Overflow), 64'(o));
        check({tag, ".vld"}, 64'(out_valid), 64'(v));
    endtask

    logic [63:0] exp_sll;
    logic [63:0] exp_srl;
    logic [63:0] exp_sra;
    logic [63:0] exp_sll0;

    initial begin
`ifdef ALU_SHIFT_EN
        exp_sll  = 64'h2;
        exp_srl  = 64'h4000_0000_0000_0000;
        exp_sra  = 64'hC000_0000_0000_0000;
        exp_sll0 = 64'h8000_0000_0000_0001;
`else
        exp_sll  = 64'h0;
        exp_srl  = 64'h0;
        exp_sra  = 64'h0;
        exp_sll0 = 64'h0;
`endif

        // Reset held with a valid ADD on the inputs.
        reset    = 1'b0;
        in_valid = 1'b1;
        A        = 64'd5;
        B        = 64'd3;
        Opcode   = 4'b0000;
        repeat (3) @(negedge clk);
        check_all("reset", 64'h0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check_all("add_after_reset", 64'd8, 1'b0, 1'b0, 1'b1);

        // ADD carry / overflow.
        drive(4'b0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
        check_all("add_carry", 64'h0, 1'b1, 1'b0, 1'b1);
        drive(4'b0000, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
        check_all("add_ovf", 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b1);
        drive(4'b0000, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1);
        check_all("add_neg_ovf", 64'h0, 1'b1, 1'b1, 1'b1);

        // SUB borrow / equal / overflow.
        drive(4'b1000, 64'd3, 64'd5, 1'b1);
        check_all("sub_neg", 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b1);
        check("sub_neg.bit63", 64'(ALUoutput[63]), 64'd1);
        drive(4'b1000, 64'd42, 64'd42, 1'b1);
        check_all("sub_eq", 64'h0, 1'b1, 1'b0, 1'b1);
        drive(4'b1000, 64'h8000_0000_0000_0000, 64'd1, 1'b1);
        check_all("sub_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b1);

        // Compares: flags cleared after a flagged ADD.
        drive(4'b0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
        drive(4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
        check_all("slt_m1_1", 64'd1, 1'b0, 1'b0, 1'b1);
        drive(4'b0011, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
        check_all("sltu_m1_1", 64'd0, 1'b0, 1'b0, 1'b1);
        drive(4'b0010, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        check("slt_1_m1", ALUoutput, 64'd0);
        drive(4'b0011, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        check("sltu_1_m1", ALUoutput, 64'd1);

        // Bitwise logic.
        drive(4'b0111, 64'hF0F0, 64'hFF00, 1'b1);
        check_all("and", 64'hF000, 1'b0, 1'b0, 1'b1);
        drive(4'b0110, 64'hF0F0, 64'hFF00, 1'b1);
        check("or", ALUoutput, 64'hFFF0);
        drive(4'b0100, 64'hF0F0, 64'hFF00, 1'b1);
        check("xor", ALUoutput, 64'h0FF0);

        // Shifts: B[63:6] must be ignored.
        drive(4'b0001, 64'h8000_0000_0000_0001, 64'h41, 1'b1);
        check_all("sll", exp_sll, 1'b0, 1'b0, 1'b1);
        drive(4'b0101, 64'h8000_0000_0000_0001, 64'h41, 1'b1);
        check("srl", ALUoutput, exp_srl);
        drive(4'b1101, 64'h8000_0000_0000_0001, 64'h41, 1'b1);
        check("sra", ALUoutput, exp_sra);
        drive(4'b0001, 64'h8000_0000_0000_0001, 64'h40, 1'b1);
        check("sll_shamt0", ALUoutput, exp_sll0);

        // Hold: in_valid=0 keeps the last result with new operands present.
        drive(4'b0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
        drive(4'b0100, 64'h1234, 64'h5678, 1'b0);
        check_all("hold", 64'h0, 1'b1, 1'b0, 1'b0);
        drive(4'b0110, 64'hF0F0, 64'hFF00, 1'b0);
        check("hold2.res", ALUoutput, 64'h0);

        // Undefined opcodes.
        drive(4'b0000, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
        drive(4'b1111, 64'h1234, 64'h5678, 1'b1);
        check_all("undef_1111", 64'h0, 1'b0, 1'b0, 1'b1);
        drive(4'b1001, 64'h1234, 64'h5678, 1'b1);
        check_all("undef_1001", 64'h0, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset between edges.
        drive(4'b0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        check("pre_async.res", ALUoutput, 64'hFFFF_FFFF_FFFF_FFFE);
        #2 reset = 1'b0;
        #1 check_all("async_reset", 64'h0, 1'b0, 1'b0, 1'b0);

        // In-flight operation lost when reset covers its sampling edge.
        @(negedge clk);
        Opcode   = 4'b0000;
        A        = 64'd10;
        B        = 64'd20;
        in_valid = 1'b1;
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check_all("inflight_discard", 64'h0, 1'b0, 1'b0, 1'b0);

        // First valid result after reset release.
        drive(4'b0000, 64'd10, 64'd20, 1'b1);
        check_all("first_after_rel", 64'd30, 1'b0, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_64bit.md
ALU_64BIT -- requirements
Module: alu_64bit

Interface
REQ-001 Parameter: WIDTH, default 64, operand/result width; only 64 is required to be supported.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-004 Port: in_valid  input  1  operands/opcode valid this cycle.
REQ-005 Port: A  input  64  first operand.
REQ-006 Port: B  input  64  second operand (register data or sign-extended immediate, selected upstream).
REQ-007 Port: Opcode  input  4  operation select, {funct7[5], funct3} RISC-V style.
REQ-008 Port: ALUoutput  output  64  registered result.
REQ-009 Port: Carry  output  1  registered carry flag.
REQ-010 Port: Overflow  output  1  registered signed-overflow flag.
REQ-011 Port: out_valid  output  1  registered copy of in_valid.

Function
REQ-012 Fixed 1-cycle latency: result for inputs sampled at edge N appears on outputs after edge N; no stall or backpressure.
REQ-013 When in_valid=0, result registers keep their previous value; out_valid goes 0.
REQ-014 Opcode 0000 ADD: A+B mod 2^64; Carry = bit 64 of unsigned sum; Overflow = signed overflow (operands same sign, result sign differs).
REQ-015 Opcode 1000 SUB: A-B mod 2^64; Carry = 1 when A>=B unsigned (no borrow); Overflow = operands differ in sign and result sign differs from A.
REQ-016 Opcode 0001 SLL: A << B[5:0], zero-fill.
REQ-017 Opcode 0010 SLT: 1 if signed A<B else 0 (zero-extended to 64 bits).
REQ-018 Opcode 0011 SLTU: 1 if unsigned A<B else 0.
REQ-019 Opcode 0100 XOR, 0110 OR, 0111 AND: bitwise.
REQ-020 Opcode 0101 SRL: A >> B[5:0], zero-fill; Opcode 1101 SRA: arithmetic shift, sign-fill.
REQ-021 Carry and Overflow are 0 for every opcode other than ADD/SUB.
REQ-022 Undefined opcodes (1001,1010,1011,1100,1110,1111): ALUoutput=0, Carry=0, Overflow=0.
REQ-023 Shift amounts use only B[5:0]; B[63:6] ignored; shift by 0 returns A unchanged.
REQ-024 SUB result is usable by downstream branch logic: zero result means A==B, bit 63 set means signed A<B absent overflow.

Reset
REQ-025 While reset=0: ALUoutput=0, Carry=0, Overflow=0, out_valid=0, immediately and independent of clk.
REQ-026 First valid result after reset deassertion appears one edge after the first in_valid=1 sample; a reset asserted mid-operation discards the in-flight result.

Configuration
REQ-027 Macro ALU_SHIFT_EN: when defined, SLL/SRL/SRA (0001, 0101, 1101) operate per REQ-020; when undefined, no shifter is built and those opcodes behave as undefined opcodes (REQ-022); all other behaviour is identical.

Verification
REQ-028 Reset: hold reset=0 with in_valid=1, A=5, B=3 -> all outputs 0; release, ADD next edge -> ALUoutput=8, Carry=0, Overflow=0, out_valid=1.
REQ-029 ADD carry/overflow: A=64'hFFFF_FFFF_FFFF_FFFF, B=1 -> ALUoutput=0, Carry=1, Overflow=0; A=64'h7FFF_FFFF_FFFF_FFFF, B=1 -> ALUoutput=64'h8000_0000_0000_0000, Carry=0, Overflow=1.
REQ-030 SUB: A=3, B=5 -> ALUoutput=64'hFFFF_FFFF_FFFF_FFFE, bit63=1, Carry=0; A=B=42 -> ALUoutput=0, Carry=1.
REQ-031 Compare: A=-1, B=1 -> SLT=1, SLTU=0; logic A=64'hF0F0, B=64'hFF00 -> AND=64'hF000, OR=64'hFFF0, XOR=64'h0FF0.
REQ-032 Shifts (ALU_SHIFT_EN defined): A=64'h8000_0000_0000_0001, B=64'h41 (shamt 1) -> SLL=64'h2, SRL=64'h4000_0000_0000_0000, SRA=64'hC000_0000_0000_0000; without the macro the same stimulus gives 0.
REQ-033 Hold/undefined: in_valid=0 after a result -> outputs unchanged, out_valid=0; Opcode=1111 with in_valid=1 -> ALUoutput=0, Carry=0, Overflow=0.
